regfile_param: RTL and testbench

Parametrised general-purpose register file for the single-cycle and pipelined CPU datapaths, replacing the fixed 32×32 two-read/one-write file. It adds configurable data width and depth, and a configurable hardwired-zero entry. A hardware clear sequencer zeroes every entry after reset. Optional same-cycle write-to-read bypass lets the file write on the rising edge and still serve decode reads in the write-back cycle.

---
 rtl/regfile_param.sv | 67 ++++++
 tb/tb_regfile_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read/1-write register file with post-reset clear sequencer
// Ports: clk, rst (async, active-high); RegWrite/RDaddr/RDdata write port;
//   RSaddr->RSdata and RTaddr->RTdata combinational read ports; busy high while clearing.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RDaddr,
  input  logic [DATA_W-1:0] RDdata,
  input  logic [ADDR_W-1:0] RSaddr,
  input  logic [ADDR_W-1:0] RTaddr,
  output logic [DATA_W-1:0] RSdata,
  output logic [DATA_W-1:0] RTdata,
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] last = (ADDR_W + 1)'(DEPTH - 1);
  localparam bit zr = ZERO_REG != 0;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic clr_we, wr_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nx;
      clr_ptr <= (state == CLEAR) ? clr_ptr + 1'b1 : clr_ptr;
    end
  always_comb begin
    state_nx = (state == CLEAR && clr_ptr == last) ? RUN : state;
    busy = state == CLEAR;
    clr_we = state == CLEAR && !rst;
    wr_en = state == RUN && !rst && RegWrite && !(zr && RDaddr == '0);
    mem_we = clr_we || wr_en;
    mem_addr = clr_we ? clr_ptr[ADDR_W-1:0] : RDaddr;
    mem_data = clr_we ? '0 : RDdata;
  end
  // The array is deliberately unreset; the sequencer defines its contents.
  always_ff @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_data;
  assign raddr[0] = RSaddr;
  assign raddr[1] = RTaddr;
  for (genvar g = 0; g < 2; g++) begin : g_rd
    always_comb begin
`ifdef REGFILE_BYPASS_EN
      rdata[g] = (busy || (zr && raddr[g] == '0)) ? '0 :
                 (wr_en && raddr[g] == RDaddr) ? RDdata : mem[raddr[g]];
`else
      rdata[g] = (busy || (zr && raddr[g] == '0)) ? '0 : mem[raddr[g]];
`endif
    end
  end
  assign RSdata = rdata[0];
  assign RTdata = rdata[1];
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed self-checking bench for regfile_param
module tb_regfile_param;
  logic clk = 0;
  logic rst = 1;
  logic RegWrite = 0;
  logic [4:0] RDaddr = 0, RSaddr = 0, RTaddr = 0;
  logic [31:0] RDdata = 0;
  logic [31:0] rs0, rt0, rs1, rt1;
  logic busy0, busy1;
  logic we2 = 0;
  logic [2:0] wa2 = 0, ra2 = 0, rb2 = 0;
  logic [15:0] wd2 = 0, rs2, rt2;
  logic busy2;
  int checks = 0, errors = 0;
  int e0, e2, bad, n;
  always #5 clk = ~clk;
  regfile_param d0 (.clk(clk), .rst(rst), .RegWrite(RegWrite), .RDaddr(RDaddr), .RDdata(RDdata),
    .RSaddr(RSaddr), .RTaddr(RTaddr), .RSdata(rs0), .RTdata(rt0), .busy(busy0));
  regfile_param #(.ZERO_REG(0)) d1 (.clk(clk), .rst(rst), .RegWrite(RegWrite), .RDaddr(RDaddr),
    .RDdata(RDdata), .RSaddr(RSaddr), .RTaddr(RTaddr), .RSdata(rs1), .RTdata(rt1), .busy(busy1));
  regfile_param #(.DATA_W(16), .ADDR_W(3)) d2 (.clk(clk), .rst(rst), .RegWrite(we2), .RDaddr(wa2),
    .RDdata(wd2), .RSaddr(ra2), .RTaddr(rb2), .RSdata(rs2), .RTdata(rt2), .busy(busy2));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1;
    RDaddr = a;
    RDdata = d;
    @(posedge clk);
    #1 RegWrite = 0;
  endtask
  task automatic count_clear(output int cnt);
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (!busy0) begin
        cnt = k;
        break;
      end
    end
  endtask
  initial begin
    RSaddr = 5;
    RTaddr = 9;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 1);
    check("rst_rs", rs0, 0);
    check("rst_rt", rt0, 0);
    check("rst_busy_small", {31'd0, busy2}, 1);
    rst = 0;
    e0 = 0;
    e2 = 0;
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (!busy2 && e2 == 0) e2 = k;
      if (busy0 && (rs0 !== 0 || rt0 !== 0 || rs1 !== 0)) bad++;
      if (!busy0) begin
        e0 = k;
        break;
      end
    end
    check("clear_edges", e0, 32);
    check("clear_edges_small", e2, 8);
    check("reads_zero_while_busy", bad, 0);
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      RSaddr = 5'(a);
      RTaddr = 5'(31 - a);
      #1;
      if (rs0 !== 0 || rt0 !== 0 || rs1 !== 0 || rt1 !== 0) bad++;
    end
    check("all_entries_zero", bad, 0);
    wr(5, 32'hDEADBEEF);
    wr(31, 32'h12345678);
    RSaddr = 5;
    RTaddr = 31;
    #1;
    check("rd_r5", rs0, 32'hDEADBEEF);
    check("rd_r31", rt0, 32'h12345678);
    RTaddr = 5;
    #1;
    check("same_rs", rs0, 32'hDEADBEEF);
    check("same_rt", rt0, 32'hDEADBEEF);
    wr(0, 32'hFFFFFFFF);
    RSaddr = 0;
    RTaddr = 0;
    #1;
    check("zero_reg_rs", rs0, 0);
    check("zero_reg_rt", rt0, 0);
    check("no_zero_reg", rs1, 32'hFFFFFFFF);
    wr(7, 32'h11);
    RegWrite = 1;
    RDaddr = 7;
    RDdata = 32'h22;
    RSaddr = 7;
    RTaddr = 5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rs0, 32'h22);
`else
    check("bypass_same_cycle", rs0, 32'h11);
`endif
    check("bypass_other_port", rt0, 32'hDEADBEEF);
    @(posedge clk);
    #1 RegWrite = 0;
    #1;
    check("bypass_next_cycle", rs0, 32'h22);
    we2 = 1;
    wa2 = 7;
    wd2 = 16'hBEEF;
    @(posedge clk);
    #1 we2 = 0;
    ra2 = 7;
    rb2 = 6;
    #1;
    check("small_r7", {16'd0, rs2}, 32'h0000BEEF);
    check("small_r6", {16'd0, rt2}, 0);
    wr(3, 32'hA5);
    RSaddr = 3;
    #1;
    check("r3_written", rs0, 32'hA5);
    rst = 1;
    #1;
    check("run_rst_busy", {31'd0, busy0}, 1);
    check("run_rst_rs", rs0, 0);
    @(negedge clk);
    rst = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1;
    check("clear_rst_busy", {31'd0, busy0}, 1);
    @(negedge clk);
    rst = 0;
    RegWrite = 1;
    RDaddr = 3;
    RDdata = 32'h77;
    count_clear(n);
    RegWrite = 0;
    check("reclear_edges", n, 32);
    RSaddr = 3;
    RTaddr = 5;
    #1;
    check("r3_cleared", rs0, 0);
    check("r5_cleared", rt0, 0);
    RSaddr = 7;
    RTaddr = 31;
    #1;
    check("r7_cleared", rs0, 0);
    check("r31_cleared", rt0, 0);
    wr(9, 32'hCAFEF00D);
    RSaddr = 9;
    #1;
    check("post_reclear_write", rs0, 32'hCAFEF00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
